// File: rtl/boot_reconfig_pkg.sv
// Shared types and defaults for the ECP5 boot/reconfiguration sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package boot_reconfig_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        QUIET  = 3'd1,
        DETACH = 3'd2,
        PROG   = 3'd3,
        DONE   = 3'd4
    } boot_seq_state_t;

    // Defaults assume a 48 MHz clock.
    localparam int unsigned DEF_QUIET_CYCLES    = 48;
    localparam int unsigned DEF_DETACH_CYCLES   = 480000;  // 10 ms SE0
    localparam int unsigned DEF_PROGRAMN_CYCLES = 4800;    // 100 us pulse
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 960000;  // 20 ms

    function automatic int unsigned cycles_max(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: dout follows din only after din has held a new value DEBOUNCE_CYCLES clocks.
// Latency: DEBOUNCE_CYCLES clocks from the first cycle of a stable new value to dout changing.
// Backpressure: none; free-running level filter.
// Ports: clk_48mhz, reset (sync, active-high), din (already synchronized), dout (registered).
module btn_debounce
    import boot_reconfig_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;

    // cnt counts consecutive cycles in which din disagrees with the filtered output.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (din == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            dout_d = din;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/boot_reconfig_seq.sv
// ECP5 reconfiguration sequencer: wait for quiet SPI/USB, force USB SE0, then pulse PROGRAMN low.
// Latency: busy rises 1 clock after the boot edge; detach after QUIET_CYCLES quiet clocks.
// Backpressure: requests arriving outside IDLE are dropped, never queued.
// Ports: clk_48mhz, reset (sync, active-high), boot (level, rising edge triggers),
//        spi_cs (1 = idle), usb_tx_en (0 = idle), btn_boot (only with BOOT_BTN_EN),
//        usb_detach (1 = SE0), user_programn (active-low), busy (not IDLE). All outputs registered.
// Optional: define BOOT_BTN_EN to add a synchronized, debounced btn_boot as a second trigger.
module boot_reconfig_seq
    import boot_reconfig_pkg::*;
#(
    parameter int unsigned QUIET_CYCLES    = DEF_QUIET_CYCLES,
    parameter int unsigned DETACH_CYCLES   = DEF_DETACH_CYCLES,
    parameter int unsigned PROGRAMN_CYCLES = DEF_PROGRAMN_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic boot,
    input  logic spi_cs,
    input  logic usb_tx_en,
    input  logic btn_boot,
    output logic usb_detach,
    output logic user_programn,
    output logic busy
);

    localparam int unsigned CMAX = cycles_max(QUIET_CYCLES, DETACH_CYCLES,
                                              PROGRAMN_CYCLES, DEBOUNCE_CYCLES);
    localparam int CW = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] QUIET_LAST  = CW'(QUIET_CYCLES - 1);
    localparam logic [CW-1:0] DETACH_LAST = CW'(DETACH_CYCLES - 1);
    localparam logic [CW-1:0] PROG_LAST   = CW'(PROGRAMN_CYCLES - 1);

    if (QUIET_CYCLES == 0) begin : g_bad_quiet
        $error("boot_reconfig_seq: QUIET_CYCLES must be >= 1");
    end
    if (DETACH_CYCLES == 0) begin : g_bad_detach
        $error("boot_reconfig_seq: DETACH_CYCLES must be >= 1");
    end
    if (PROGRAMN_CYCLES == 0) begin : g_bad_prog
        $error("boot_reconfig_seq: PROGRAMN_CYCLES must be >= 1");
    end
    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("boot_reconfig_seq: DEBOUNCE_CYCLES must be >= 1");
    end

    boot_seq_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            boot_q, boot_d;
    logic            busy_q, busy_d;
    logic            detach_q, detach_d;
    logic            programn_q, programn_d;
    logic            btn_trig;
    logic            trig;
    logic            bus_quiet;

`ifdef BOOT_BTN_EN
    logic btn_s1_q, btn_s2_q, btn_db, btn_db_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_48mhz(clk_48mhz),
        .reset    (reset),
        .din      (btn_s2_q),
        .dout     (btn_db)
    );

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_s1_q <= btn_boot;
            btn_s2_q <= btn_s1_q;
            btn_db_q <= btn_db;
        end
    end

    assign btn_trig = btn_db & ~btn_db_q;
`else
    logic unused_btn_boot;
    assign unused_btn_boot = btn_boot;
    assign btn_trig        = 1'b0;
`endif

    // boot_q resets high so a boot level already asserted through reset is not an edge.
    assign trig      = (boot & ~boot_q) | btn_trig;
    assign bus_quiet = spi_cs & ~usb_tx_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        boot_d  = boot;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = QUIET;
                    cnt_d   = '0;
                end
            end
            QUIET: begin
                // Only an unbroken run of quiet cycles counts; any activity restarts it.
                if (!bus_quiet) begin
                    cnt_d = '0;
                end else if (cnt_q == QUIET_LAST) begin
                    state_d = DETACH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DETACH: begin
                if (cnt_q == DETACH_LAST) begin
                    state_d = PROG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PROG: begin
                if (cnt_q == PROG_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs decoded from the next state so they switch with the state register.
        busy_d     = (state_d != IDLE);
        detach_d   = (state_d == DETACH) || (state_d == PROG) || (state_d == DONE);
        programn_d = (state_d != PROG);
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            boot_q     <= 1'b1;
            busy_q     <= 1'b0;
            detach_q   <= 1'b0;
            programn_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            boot_q     <= boot_d;
            busy_q     <= busy_d;
            detach_q   <= detach_d;
            programn_q <= programn_d;
        end
    end

    assign usb_detach    = detach_q;
    assign user_programn = programn_q;
    assign busy          = busy_q;

endmodule
